// File: rtl/mem_bridge_pkg.sv
// Shared types for the two-master memory bridge: return-source tags and bus sizing.
package mem_bridge_pkg;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_e;

    typedef struct packed {
        logic valid;
        src_e src;
    } tag_t;

    function automatic int unsigned sel_width(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// Fixed-depth shift register of read tags; the tail lines up with memory read data.
module mem_tag_pipe
    import mem_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  tag_t push_i,
    output tag_t tail_o
);

    tag_t [DEPTH-1:0] stage_q;
    tag_t [DEPTH-1:0] stage_d;

    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = push_i;
        for (int k = 1; k < int'(DEPTH); k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter_bridge.sv
// Instruction/data to single-memory bridge: data-priority arbiter with a starvation
// guard, pipelined read-tag tracking and per-channel held read data.
module mem_arbiter_bridge
    import mem_bridge_pkg::*;
#(
    parameter  int unsigned ADDR_W       = 32,
    parameter  int unsigned DATA_W       = 32,
    parameter  int unsigned MEM_LATENCY  = 1,
    parameter  int unsigned STARVE_LIMIT = 4,
    localparam int unsigned SEL_W        = sel_width(DATA_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_req_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [DATA_W-1:0] i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [SEL_W-1:0]  d_sel_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_ce_o,
    output logic [SEL_W-1:0]  mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                i_rvalid_q, i_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    tag_t                push_tag;
    tag_t                tail_tag;

    // Arbitration, streak tracking and memory drive; grants are forced low in reset.
    always_comb begin
        i_gnt_o  = 1'b0;
        d_gnt_o  = 1'b0;
        streak_d = streak_q;

        if (rst_i) begin
            if (d_req_i && (!i_req_i || (streak_q < LIMIT))) begin
                d_gnt_o = 1'b1;
            end else if (i_req_i) begin
                i_gnt_o = 1'b1;
            end
        end

        if (!i_req_i || i_gnt_o) begin
            streak_d = '0;
        end else if (d_gnt_o && (streak_q < LIMIT)) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        mem_ce_o    = i_gnt_o | d_gnt_o;
        mem_addr_o  = i_gnt_o ? i_addr_i : d_addr_i;
        mem_we_o    = (d_gnt_o && d_we_i) ? d_sel_i : '0;
        mem_wdata_o = d_wdata_i;

        push_tag.valid = i_gnt_o | (d_gnt_o & ~d_we_i);
        push_tag.src   = d_gnt_o ? SRC_D : SRC_I;
    end

    mem_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (push_tag),
        .tail_o (tail_tag)
    );

    // Return steering: the tail tag picks which channel captures this cycle's read data.
    always_comb begin
        i_rvalid_d = tail_tag.valid && (tail_tag.src == SRC_I);
        d_rvalid_d = tail_tag.valid && (tail_tag.src == SRC_D);
        i_rdata_d  = i_rvalid_d ? mem_rdata_i : i_rdata_q;
        d_rdata_d  = d_rvalid_d ? mem_rdata_i : d_rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            streak_q   <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            streak_q   <= streak_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign i_rvalid_o = i_rvalid_q;
    assign d_rvalid_o = d_rvalid_q;
    assign i_rdata_o  = i_rdata_q;
    assign d_rdata_o  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter_bridge.sv
// Bench for mem_arbiter_bridge: three instances (latency 1..3) share one stimulus stream;
// a reference model predicts grants and returns, a negedge monitor scores the returns.
module tb_mem_arbiter_bridge;

    localparam int NINST = 3;
    localparam int LIMIT = 4;

    typedef struct {
        int          inst;
        logic        src;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;

    logic        i_gnt    [NINST];
    logic        d_gnt    [NINST];
    logic        i_rvalid [NINST];
    logic        d_rvalid [NINST];
    logic        mem_ce   [NINST];
    logic [3:0]  mem_we   [NINST];
    logic [31:0] mem_addr [NINST];
    logic [31:0] mem_wdata[NINST];
    logic [31:0] i_rdata  [NINST];
    logic [31:0] d_rdata  [NINST];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          streak_m = 0;
    logic [31:0] ref_mem [256];
    logic [31:0] hold_i  [NINST];
    logic [31:0] hold_d  [NINST];
    exp_t        exp_q   [$];

    function automatic logic [31:0] init_word(input int w);
        if (w == 64) return 32'hDEADBEEF;
        if (w == 8)  return 32'h0;
        return 32'h1000_0000 + 32'(w) * 32'h0001_0101;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check(input string name, input int k, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[lat%0d] cyc=%0d act=%0h exp=%0h", name, k + 1, cyc, act, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NINST; g++) begin : g_inst
        localparam int unsigned LAT = g + 1;
        logic [31:0] mem  [256];
        logic [31:0] pipe [LAT];

        mem_arbiter_bridge #(
            .ADDR_W       (32),
            .DATA_W       (32),
            .MEM_LATENCY  (LAT),
            .STARVE_LIMIT (LIMIT)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst_n),
            .i_req_i     (i_req),
            .i_addr_i    (i_addr),
            .i_gnt_o     (i_gnt[g]),
            .i_rvalid_o  (i_rvalid[g]),
            .i_rdata_o   (i_rdata[g]),
            .d_req_i     (d_req),
            .d_we_i      (d_we),
            .d_sel_i     (d_sel),
            .d_addr_i    (d_addr),
            .d_wdata_i   (d_wdata),
            .d_gnt_o     (d_gnt[g]),
            .d_rvalid_o  (d_rvalid[g]),
            .d_rdata_o   (d_rdata[g]),
            .mem_ce_o    (mem_ce[g]),
            .mem_we_o    (mem_we[g]),
            .mem_addr_o  (mem_addr[g]),
            .mem_wdata_o (mem_wdata[g]),
            .mem_rdata_i (pipe[LAT-1])
        );

        initial for (int w = 0; w < 256; w++) mem[w] <= init_word(w);

        // Memory with a LAT-deep read pipeline; returns junk when not enabled.
        always @(posedge clk) begin
            if (mem_ce[g] && (mem_we[g] != 4'b0))
                mem[mem_addr[g][9:2]] <= merge(mem[mem_addr[g][9:2]], mem_wdata[g], mem_we[g]);
            pipe[0] <= mem_ce[g] ? mem[mem_addr[g][9:2]] : $urandom;
            for (int k = 1; k < int'(LAT); k++) pipe[k] <= pipe[k-1];
        end
    end

    // One bus cycle: drive inputs, check combinational grants/bus, update the model.
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic dw, input logic [3:0] ds, input logic [31:0] da,
                         input logic [31:0] dd, input logic rv = 1'b1);
        logic eg_i, eg_d;
        @(posedge clk);
        #1;
        rst_n = rv; i_req = ir; i_addr = ia; d_req = dr; d_we = dw;
        d_sel = ds; d_addr = da; d_wdata = dd;
        #1;
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (rv) begin
            if (dr && (!ir || streak_m < LIMIT)) eg_d = 1'b1;
            else if (ir)                         eg_i = 1'b1;
        end
        for (int k = 0; k < NINST; k++) begin
            check("grant", k, 128'({i_gnt[k], d_gnt[k], mem_ce[k]}),
                  128'({eg_i, eg_d, eg_i | eg_d}));
            check("bus", k, 128'({mem_we[k], mem_addr[k], mem_wdata[k]}),
                  128'({(eg_d && dw) ? ds : 4'b0, eg_i ? ia : da, dd}));
        end
        if (!rv || !ir || eg_i) streak_m = 0;
        else if (eg_d && streak_m < LIMIT) streak_m++;
        if (eg_d && dw) begin
            ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], dd, ds);
        end else if (eg_i || eg_d) begin
            for (int k = 0; k < NINST; k++)
                exp_q.push_back('{inst: k, src: eg_d, data: ref_mem[eg_i ? ia[9:2] : da[9:2]],
                                  due: cyc + k + 2});
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Return monitor: pops the oldest expectation per instance when it falls due.
    always @(negedge clk) begin
        int         idx;
        logic [1:0] ev;
        if (!rst_n) begin
            exp_q.delete();
            for (int k = 0; k < NINST; k++) begin
                hold_i[k] = 32'h0;
                hold_d[k] = 32'h0;
            end
        end
        for (int k = 0; k < NINST; k++) begin
            idx = -1;
            ev  = 2'b00;
            foreach (exp_q[j]) if (idx < 0 && exp_q[j].inst == k) idx = j;
            if (idx >= 0 && exp_q[idx].due == cyc) begin
                if (exp_q[idx].src) begin
                    ev = 2'b01;
                    hold_d[k] = exp_q[idx].data;
                end else begin
                    ev = 2'b10;
                    hold_i[k] = exp_q[idx].data;
                end
                exp_q.delete(idx);
            end
            check("rvalid", k, 128'({i_rvalid[k], d_rvalid[k]}), 128'(ev));
            check("i_rdata", k, 128'(i_rdata[k]), 128'(hold_i[k]));
            check("d_rdata", k, 128'(d_rdata[k]), 128'(hold_d[k]));
        end
    end

    initial begin
        string gseq;
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_sel = '0; d_addr = '0; d_wdata = '0;
        for (int w = 0; w < 256; w++) ref_mem[w] = init_word(w);

        for (int c = 0; c < 3; c++) drive(1'b1, 32'h4, 1'b1, 1'b1, 4'hF, 32'h8, 32'h0, 1'b0);
        idle(2);

        // Lone instruction read of 0x100.
        drive(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle(5);
        for (int k = 0; k < NINST; k++) check("i_hold_beef", k, 128'(i_rdata[k]), 128'h0DEADBEEF);

        // Back-to-back I, D, I reads.
        drive(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
        drive(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        idle(5);

        // Both masters requesting continuously: starvation guard pattern.
        gseq = "";
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 32'h40 + 32'(4 * c), 1'b1, 1'b0, 4'h0, 32'h80 + 32'(4 * c), 32'h0);
            if (d_gnt[0])      gseq = {gseq, "D"};
            else if (i_gnt[0]) gseq = {gseq, "I"};
            else               gseq = {gseq, "-"};
        end
        n_checks++;
        if (gseq != "DDDDIDDDDI") begin
            n_fail++;
            $display("FAIL grant_seq act=%s exp=DDDDIDDDDI", gseq);
        end
        idle(5);

        // Partial byte write, zero-enable write, then read back.
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'h12345678);
        drive(1'b0, 32'h0, 1'b1, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        idle(5);
        for (int k = 0; k < NINST; k++) check("d_byte_write", k, 128'(d_rdata[k]), 128'h00005678);

        // Reset with reads in flight.
        drive(1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h14, 32'h0);
        drive(1'b1, 32'h18, 1'b1, 1'b0, 4'h0, 32'h1C, 32'h0, 1'b0);
        idle(6);
        for (int k = 0; k < NINST; k++)
            check("rdata_after_rst", k, 128'({i_rdata[k], d_rdata[k]}), 128'h0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  4'($urandom), 32'($urandom_range(0, 15)) << 2, $urandom,
                  1'($urandom_range(0, 99) != 0));
        end
        idle(8);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain act=%0d pending exp=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
